i2c_master_tx: RTL and testbench
================================

I2C_MASTER_TX -- requirements
Module: i2c_master_tx

Interface
REQ-001 Parameter CLK_DIV, default 4, means clk cycles per SCL quarter-period phase; legal values are 4 or more.
REQ-002 Parameter SLAVE_ADDR, default 7'b1010101, is the 7-bit target address.
REQ-003 Port clk, input, 1 bit: system clock; all logic is on its rising edge.
REQ-004 Port reset, input, 1 bit: reset, asynchronous, active-high.
REQ-005 Port start, input, 1 bit: one-cycle request to send one frame.
REQ-006 Ports tx_byte0..tx_byte5, input, 8 bits each: payload bytes, sent in order 0 to 5.
REQ-007 Port SCL, output, 1 bit: I2C clock, driven push-pull.
REQ-008 Port SDA, inout, 1 bit: I2C data, open-drain; drives 0 or Z, never drives 1.
REQ-009 Port busy, output, 1 bit: high while a frame is in progress.
REQ-010 Port done, output, 1 bit: one-cycle pulse when a frame ends.
REQ-011 Port ack_err, output, 1 bit: the last frame ended on a NACK; holds until the next accepted start.

Function
REQ-012 The block shall contain a phase-tick counter running 0..CLK_DIV-1 while busy; a "phase" ends on each wrap.
REQ-013 The FSM states shall be IDLE, START, ADDR, ADDR_ACK, DATA, DATA_ACK, STOP, DONE.
REQ-014 In IDLE: SCL=1, SDA released, busy=0.
REQ-015 In IDLE, start=1 shall latch tx_byte0..5 and the shift register {SLAVE_ADDR,1'b0} (write), clear ack_err, and enter START; busy rises the next cycle.
REQ-016 start while busy shall be ignored.
REQ-017 START shall last 2 phases: phase 0 SCL=1/SDA released, phase 1 SCL=1/SDA=0; then enter ADDR.
REQ-018 Each bit slot shall last 4 phases: p0 SCL=0 with SDA set to the bit (MSB first), p1-p2 SCL=1, p3 SCL=0 with SDA held.
REQ-019 ADDR and DATA shall each send 8 bits using a 3-bit bit counter; after bit 7 they enter ADDR_ACK or DATA_ACK.
REQ-020 ACK slots shall release SDA for all 4 phases and sample SDA at the end of p2.
REQ-021 SDA shall be sampled through a 2-flop synchronizer, reset value 1.
REQ-022 Sampled SDA=0 is an ACK: ADDR_ACK goes to DATA with byte 0; DATA_ACK goes to DATA with the next byte.
REQ-023 DATA_ACK after byte 5 with ACK shall go to STOP.
REQ-024 A sampled SDA=1 in any ACK slot shall set ack_err=1 and go directly to STOP; the remaining bytes are not sent.
REQ-025 STOP shall last 3 phases: SCL=0/SDA=0, then SCL=1/SDA=0, then SCL=1/SDA released (rising SDA while SCL is high); then enter DONE.
REQ-026 DONE shall last one clk: done=1 and busy=0 in that cycle, then return to IDLE.
REQ-027 SCL and SDA transitions shall occur only at phase boundaries, so SDA never changes while SCL=1 except in START and STOP.
REQ-028 Full frame length shall be 2 + 63*4 + 3 = 257 phases, i.e. 257*CLK_DIV clk cycles from the first START cycle to DONE.
REQ-029 The byte index shall be 0..5 and shall not wrap within a frame.

Reset
REQ-030 reset shall force state=IDLE, SCL=1, SDA released, busy=0, done=0, ack_err=0, counters=0, and synchronizer=1.
REQ-031 reset asserted mid-frame shall abort immediately with no STOP generated; the bus is released on the same edge.
REQ-032 After reset deasserts, the first start shall be accepted normally.

Verification
REQ-033 Bench shall drive start with bytes 11,22,33,44,55,66 and an ACKing slave model at 0x55 -> SDA carries 0xAA, then 0x11..0x66, each followed by a released ACK slot; done pulses after 1028 clk (CLK_DIV=4); ack_err=0.
REQ-034 Bench shall run a slave that NACKs the address -> only 9 bit slots, then STOP; ack_err=1; done pulses; SCL ends at 1.
REQ-035 Bench shall run a slave that NACKs byte 2 -> bytes 0-2 sent, STOP follows, ack_err=1, and bytes 3-5 never appear on SDA.
REQ-036 Bench shall pulse start again 100 cycles into a frame -> no effect; the frame contents and length are unchanged.
REQ-037 Bench shall assert reset during DATA byte 3 -> SCL=1, SDA=Z, busy=0 immediately; a new start then sends a complete frame.
REQ-038 Bench shall run back-to-back frames, with start in the cycle after done -> second frame accepted; START condition seen (SDA falls while SCL=1).

Source files
------------

// File: rtl/i2c_master_tx.sv
// Write-only I2C master: START, address+W, six payload bytes with ACK checks, STOP.
// SCL is push-pull; SDA is open-drain and read back through a 2-flop synchronizer.
module i2c_master_tx #(
    parameter int unsigned CLK_DIV    = 4,
    parameter logic [6:0]  SLAVE_ADDR = 7'b1010101
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] tx_byte0,
    input  logic [7:0] tx_byte1,
    input  logic [7:0] tx_byte2,
    input  logic [7:0] tx_byte3,
    input  logic [7:0] tx_byte4,
    input  logic [7:0] tx_byte5,
    output logic       SCL,
    inout  wire        SDA,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    output logic [2:0] o_dbg_state
);
    localparam int TW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [TW-1:0] TICK_MAX = TW'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        START    = 3'd1,
        ADDR     = 3'd2,
        ADDR_ACK = 3'd3,
        DATA     = 3'd4,
        DATA_ACK = 3'd5,
        STOP     = 3'd6,
        DONE     = 3'd7
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [TW-1:0]   r_tick;
    logic [1:0]      r_phase;
    logic [2:0]      r_bit;
    logic [2:0]      r_byte;
    logic [7:0]      r_shift;
    logic [47:0]     r_payload;
    logic            r_sda_s1;
    logic            r_sda_s2;
    logic            r_sample;
    logic            r_ack_err;
    logic            w_in_frame;
    logic            w_phase_end;
    logic            w_slot_end;
    logic            w_sda_low;

    assign w_in_frame  = (r_state != IDLE) && (r_state != DONE);
    assign w_phase_end = w_in_frame && (r_tick == TICK_MAX);
    assign w_slot_end  = w_phase_end && (r_phase == 2'd3);

    assign SDA         = w_sda_low ? 1'b0 : 1'bz;
    assign busy        = w_in_frame;
    assign done        = (r_state == DONE);
    assign ack_err     = r_ack_err;
    assign o_dbg_state = r_state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_next;
    end

    // Bit slots: p0 SCL low with new data, p1-p2 SCL high, p3 SCL low with data held.
    always_comb begin
        w_state_next = r_state;
        SCL          = 1'b1;
        w_sda_low    = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) w_state_next = START;
            end
            START: begin
                w_sda_low = (r_phase == 2'd1);
                if (w_phase_end && (r_phase == 2'd1)) w_state_next = ADDR;
            end
            ADDR, DATA: begin
                SCL       = (r_phase == 2'd1) || (r_phase == 2'd2);
                w_sda_low = ~r_shift[7];
                if (w_slot_end && (r_bit == 3'd7))
                    w_state_next = (r_state == ADDR) ? ADDR_ACK : DATA_ACK;
            end
            ADDR_ACK: begin
                SCL = (r_phase == 2'd1) || (r_phase == 2'd2);
                if (w_slot_end) w_state_next = r_sample ? STOP : DATA;
            end
            DATA_ACK: begin
                SCL = (r_phase == 2'd1) || (r_phase == 2'd2);
                if (w_slot_end)
                    w_state_next = (r_sample || (r_byte == 3'd5)) ? STOP : DATA;
            end
            STOP: begin
                SCL       = (r_phase != 2'd0);
                w_sda_low = (r_phase != 2'd2);
                if (w_phase_end && (r_phase == 2'd2)) w_state_next = DONE;
            end
            DONE: begin
                w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tick    <= '0;
            r_phase   <= 2'd0;
            r_bit     <= 3'd0;
            r_byte    <= 3'd0;
            r_shift   <= 8'h00;
            r_payload <= 48'h0;
            r_sda_s1  <= 1'b1;
            r_sda_s2  <= 1'b1;
            r_sample  <= 1'b0;
            r_ack_err <= 1'b0;
        end else begin
            r_sda_s1 <= SDA;
            r_sda_s2 <= r_sda_s1;
            r_tick   <= (w_in_frame && (r_tick != TICK_MAX)) ? r_tick + TW'(1) : '0;

            if (!w_in_frame)
                r_phase <= 2'd0;
            else if (w_phase_end)
                r_phase <= (w_state_next != r_state) ? 2'd0 : r_phase + 2'd1;

            if ((r_state == IDLE) && start) begin
                r_shift   <= {SLAVE_ADDR, 1'b0};
                r_payload <= {tx_byte0, tx_byte1, tx_byte2, tx_byte3, tx_byte4, tx_byte5};
                r_bit     <= 3'd0;
                r_byte    <= 3'd0;
                r_ack_err <= 1'b0;
            end

            if (((r_state == ADDR) || (r_state == DATA)) && w_slot_end) begin
                r_shift <= {r_shift[6:0], 1'b0};
                r_bit   <= r_bit + 3'd1;
            end

            // The slave's answer is taken at the end of the second SCL-high phase.
            if (((r_state == ADDR_ACK) || (r_state == DATA_ACK)) && w_phase_end && (r_phase == 2'd2))
                r_sample <= r_sda_s2;

            if (((r_state == ADDR_ACK) || (r_state == DATA_ACK)) && w_slot_end) begin
                if (r_sample) begin
                    r_ack_err <= 1'b1;
                end else if (w_state_next == DATA) begin
                    r_shift   <= r_payload[47:40];
                    r_payload <= {r_payload[39:0], 8'h00};
                    if (r_state == DATA_ACK) r_byte <= r_byte + 3'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_i2c_master_tx.sv
// Bench for i2c_master_tx: an I2C slave model feeds received bytes to a scoreboard
// queue; directed frames cover ACK, NACK, ignored start, mid-frame reset and back-to-back.
module tb_i2c_master_tx;
    localparam int         CLK_DIV   = 4;
    localparam logic [7:0] ADDR_BYTE = {7'b1010101, 1'b0};

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [7:0] tx_b [0:5];
    logic       scl;
    wire        sda_bus;
    logic       busy;
    logic       done;
    logic       ack_err;
    logic [2:0] dbg_state;
    logic       slv_drv = 1'b0;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_q[$];

    assign sda_bus = slv_drv ? 1'b0 : 1'bz;
    pullup (sda_bus);

    i2c_master_tx #(.CLK_DIV(CLK_DIV), .SLAVE_ADDR(7'b1010101)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .tx_byte0    (tx_b[0]),
        .tx_byte1    (tx_b[1]),
        .tx_byte2    (tx_b[2]),
        .tx_byte3    (tx_b[3]),
        .tx_byte4    (tx_b[4]),
        .tx_byte5    (tx_b[5]),
        .SCL         (scl),
        .SDA         (sda_bus),
        .busy        (busy),
        .done        (done),
        .ack_err     (ack_err),
        .o_dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    // Slave model, sampled on the falling clk edge away from DUT updates
    int         nack_idx = -1;
    int         byte_idx = 0;
    int         k = 0;
    logic [7:0] sh = 8'h00;
    logic       prev_scl = 1'b1;
    logic       prev_sda = 1'b1;
    int         rise_cnt = 0;
    int         start_total = 0;
    int         stop_total = 0;
    int         rx_total = 0;

    always @(negedge clk) begin
        logic [7:0] e;
        prev_scl <= scl;
        prev_sda <= sda_bus;
        if (reset) begin
            slv_drv <= 1'b0;
            k       <= 0;
        end else if (prev_scl && scl && prev_sda && !sda_bus) begin
            start_total <= start_total + 1;
            rise_cnt    <= 0;
            k           <= 0;
            byte_idx    <= 0;
            slv_drv     <= 1'b0;
        end else if (prev_scl && scl && !prev_sda && sda_bus) begin
            stop_total <= stop_total + 1;
        end else if (!prev_scl && scl) begin
            rise_cnt <= rise_cnt + 1;
            if (k < 8) begin
                sh <= {sh[6:0], sda_bus};
                k  <= k + 1;
            end else if (k == 8) begin
                if (!slv_drv) check("ack_slot_released", {31'h0, sda_bus}, 32'h1);
                k <= 9;
            end
        end else if (prev_scl && !scl) begin
            if (k == 8) begin
                rx_total <= rx_total + 1;
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("rx_byte", {24'h0, sh}, {24'h0, e});
                end else begin
                    check("rx_byte_unexpected", {24'h0, sh}, 32'h100);
                end
                slv_drv <= (byte_idx != nack_idx);
            end else if (k == 9) begin
                slv_drv  <= 1'b0;
                k        <= 0;
                byte_idx <= byte_idx + 1;
            end
        end
    end

    // nack: slave byte index to NACK (0 = address), -1 for none
    task automatic run_frame(input int nack, input bit extra_start, input string tag);
        int nbytes;
        int cyc;
        int st0;
        int sp0;
        nbytes   = (nack < 0) ? 7 : nack + 1;
        nack_idx = nack;
        exp_q.push_back(ADDR_BYTE);
        for (int i = 0; i < nbytes - 1; i++) exp_q.push_back(tx_b[i]);
        st0 = start_total;
        sp0 = stop_total;
        @(posedge clk); #1; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        check({tag, "_busy_rise"}, {31'h0, busy}, 32'h1);
        check({tag, "_ack_err_clear"}, {31'h0, ack_err}, 32'h0);
        cyc = 0;
        while (!done && cyc < 5000) begin
            @(posedge clk); #1;
            cyc++;
            if (extra_start) start = (cyc == 100);
        end
        start = 1'b0;
        check({tag, "_done"}, {31'h0, done}, 32'h1);
        check({tag, "_busy_at_done"}, {31'h0, busy}, 32'h0);
        check({tag, "_cycles"}, cyc, (5 + 36 * nbytes) * CLK_DIV);
        check({tag, "_ack_err"}, {31'h0, ack_err}, {31'h0, (nack >= 0)});
        check({tag, "_scl_end"}, {31'h0, scl}, 32'h1);
        check({tag, "_scl_rises"}, rise_cnt, 9 * nbytes + 1);
        check({tag, "_start_cond"}, start_total - st0, 1);
        check({tag, "_stop_cond"}, stop_total - sp0, 1);
        check({tag, "_queue_empty"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        int cyc;
        int rx0;
        for (int i = 0; i < 6; i++) tx_b[i] = 8'h11 * (i + 1);

        // Clock/reset
        repeat (3) @(posedge clk);
        #1;
        check("rst_scl", {31'h0, scl}, 32'h1);
        check("rst_sda", {31'h0, sda_bus}, 32'h1);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_done", {31'h0, done}, 32'h0);
        check("rst_ack_err", {31'h0, ack_err}, 32'h0);
        check("rst_state", {29'h0, dbg_state}, 32'h0);
        @(negedge clk) reset = 1'b0;

        run_frame(-1, 1'b0, "full");
        run_frame(0, 1'b0, "nack_addr");
        repeat (20) @(posedge clk);
        #1;
        check("ack_err_hold", {31'h0, ack_err}, 32'h1);
        run_frame(3, 1'b0, "nack_byte2");
        run_frame(-1, 1'b1, "ignored_start");

        // Abort with reset in the middle of payload byte 3
        nack_idx = -1;
        exp_q.push_back(ADDR_BYTE);
        for (int i = 0; i < 3; i++) exp_q.push_back(tx_b[i]);
        rx0 = rx_total;
        @(posedge clk); #1; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        cyc = 0;
        while (rx_total < rx0 + 4 && cyc < 5000) begin
            @(posedge clk); #1;
            cyc++;
        end
        repeat (40) @(posedge clk);
        #1;
        check("abort_in_data", {29'h0, dbg_state}, 32'h4);
        check("abort_rx_count", rx_total - rx0, 4);
        @(negedge clk) reset = 1'b1;
        #1;
        check("abort_scl", {31'h0, scl}, 32'h1);
        check("abort_sda", {31'h0, sda_bus}, 32'h1);
        check("abort_busy", {31'h0, busy}, 32'h0);
        check("abort_state", {29'h0, dbg_state}, 32'h0);
        check("abort_queue_empty", exp_q.size(), 0);
        @(negedge clk);
        @(negedge clk) reset = 1'b0;
        exp_q.delete();

        for (int i = 0; i < 6; i++) tx_b[i] = 8'($urandom_range(0, 255));
        run_frame(-1, 1'b0, "after_reset");
        for (int i = 0; i < 6; i++) tx_b[i] = 8'($urandom_range(0, 255));
        run_frame(-1, 1'b0, "b2b_first");
        run_frame(-1, 1'b0, "b2b_second");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
